// File: rtl/vga_line_requester.sv
// VGA timing generator + per-line FIFO load requester; pixels/syncs leave one register stage after the counters.
// No backpressure: an empty FIFO in the active area shows black and flags underflow (VGA_UNDERFLOW_CNT_EN adds a saturating count).
module vga_line_requester #(
  parameter int H_ACTIVE     = 1280,
  parameter int H_TOTAL      = 1688,
  parameter int H_SYNC_START = 1328,
  parameter int H_SYNC_END   = 1440,
  parameter int V_ACTIVE     = 1024,
  parameter int V_TOTAL      = 1066,
  parameter int V_SYNC_START = 1025,
  parameter int V_SYNC_END   = 1028
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [5:0]  iFRAME_ID,
  input  logic        iOFFSET_H_SIGN,
  input  logic [7:0]  iOFFSET_H,
  input  logic        iOFFSET_V_SIGN,
  input  logic [7:0]  iOFFSET_V,
  output logic [5:0]  oFRAME_ID,
  output logic        oOFFSET_H_SIGN,
  output logic [7:0]  oOFFSET_H,
  output logic        oOFFSET_V_SIGN,
  output logic [7:0]  oOFFSET_V,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  input  logic        iFIFO_EMPTY,
  input  logic [7:0]  iFIFO_RDATA,
  output logic        oFIFO_RDREQ,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oUNDERFLOW,
  output logic [15:0] oUNDERFLOW_CNT
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int LW = 13;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_REQ  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
  localparam logic [LW-1:0] V_ACT  = LW'(V_ACTIVE);
  localparam logic [LW-1:0] V_LAST = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] V_SS   = LW'(V_SYNC_START);
  localparam logic [LW-1:0] V_SE   = LW'(V_SYNC_END);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic [5:0] frame_id;
    logic       h_sign;
    logic [7:0] h_off;
    logic       v_sign;
    logic [7:0] v_off;
  } frame_cfg_t;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [LW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  frame_cfg_t    cfg_q, cfg_d;
  logic [7:0]    pix_q, pix_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic          uf_q, uf_d;

  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          rd_en;
  logic          uf_evt;
  logic [LW-1:0] next_line;

  // Raster counters
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    rd_en  = active && !iFIFO_EMPTY;
    uf_evt = active && iFIFO_EMPTY;
  end

  // Decode on the incoming count so the REQ cycle coincides with h_cnt==H_ACTIVE-1.
  always_comb begin
    next_line = (v_cnt_d == V_LAST) ? '0 : v_cnt_d + 1'b1;
    state_d   = state_q;
    line_d    = line_q;
    case (state_q)
      ST_IDLE: begin
        if ((h_cnt_d == H_REQ) && (next_line < V_ACT)) begin
          state_d = ST_REQ;
          line_d  = next_line;
        end
      end
      ST_REQ:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (h_wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame parameters only move on the last blank line so a frame never sees a torn setting.
  always_comb begin
    cfg_d = cfg_q;
    if ((h_cnt_q == '0) && v_wrap) begin
      cfg_d.frame_id = iFRAME_ID;
      cfg_d.h_sign   = iOFFSET_H_SIGN;
      cfg_d.h_off    = iOFFSET_H;
      cfg_d.v_sign   = iOFFSET_V_SIGN;
      cfg_d.v_off    = iOFFSET_V;
    end
  end

  always_comb begin
    pix_d     = rd_en ? iFIFO_RDATA : 8'd0;
    hs_d      = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
    vs_d      = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    blank_n_d = active;
    uf_d      = uf_q | uf_evt;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= V_LAST;
      state_q   <= ST_IDLE;
      line_q    <= '0;
      cfg_q     <= '0;
      pix_q     <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_n_q <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      state_q   <= state_d;
      line_q    <= line_d;
      cfg_q     <= cfg_d;
      pix_q     <= pix_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      uf_q      <= uf_d;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (uf_evt && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign oUNDERFLOW_CNT = uf_cnt_q;
`else
  assign oUNDERFLOW_CNT = 16'd0;
`endif

  assign oFRAME_ID             = cfg_q.frame_id;
  assign oOFFSET_H_SIGN        = cfg_q.h_sign;
  assign oOFFSET_H             = cfg_q.h_off;
  assign oOFFSET_V_SIGN        = cfg_q.v_sign;
  assign oOFFSET_V             = cfg_q.v_off;
  assign oVGA_LINE_TO_LOAD     = line_q;
  assign oVGA_LOAD_TO_FIFO_REQ = (state_q == ST_REQ);
  assign oFIFO_RDREQ           = rd_en;
  assign oVGA_R                = pix_q;
  assign oVGA_G                = pix_q;
  assign oVGA_B                = pix_q;
  assign oVGA_HS               = hs_q;
  assign oVGA_VS               = vs_q;
  assign oVGA_BLANK_N          = blank_n_q;
  assign oUNDERFLOW            = uf_q;

endmodule

// File: tb/tb_vga_line_requester.sv
// Bench for vga_line_requester on a shrunken raster; reference model derives raster position from the cycle count.
module tb_vga_line_requester;

  localparam int HA = 40, HT = 56, HSS = 44, HSE = 48;
  localparam int VA = 12, VT = 16, VSS = 13, VSE = 14;
  localparam int FRAME = HT * VT;

  logic        iCLK, iRST;
  logic [5:0]  iFRAME_ID;
  logic        iOFFSET_H_SIGN, iOFFSET_V_SIGN;
  logic [7:0]  iOFFSET_H, iOFFSET_V;
  logic [5:0]  oFRAME_ID;
  logic        oOFFSET_H_SIGN, oOFFSET_V_SIGN;
  logic [7:0]  oOFFSET_H, oOFFSET_V;
  logic [12:0] oVGA_LINE_TO_LOAD;
  logic        oVGA_LOAD_TO_FIFO_REQ;
  logic        iFIFO_EMPTY;
  logic [7:0]  iFIFO_RDATA;
  logic        oFIFO_RDREQ;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oUNDERFLOW;
  logic [15:0] oUNDERFLOW_CNT;

  vga_line_requester #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iFRAME_ID(iFRAME_ID), .iOFFSET_H_SIGN(iOFFSET_H_SIGN), .iOFFSET_H(iOFFSET_H),
    .iOFFSET_V_SIGN(iOFFSET_V_SIGN), .iOFFSET_V(iOFFSET_V),
    .oFRAME_ID(oFRAME_ID), .oOFFSET_H_SIGN(oOFFSET_H_SIGN), .oOFFSET_H(oOFFSET_H),
    .oOFFSET_V_SIGN(oOFFSET_V_SIGN), .oOFFSET_V(oOFFSET_V),
    .oVGA_LINE_TO_LOAD(oVGA_LINE_TO_LOAD), .oVGA_LOAD_TO_FIFO_REQ(oVGA_LOAD_TO_FIFO_REQ),
    .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_RDATA(iFIFO_RDATA), .oFIFO_RDREQ(oFIFO_RDREQ),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oUNDERFLOW(oUNDERFLOW), .oUNDERFLOW_CNT(oUNDERFLOW_CNT)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int errors = 0;
  int checks = 0;

  // Stimulus settings applied each cycle
  logic       in_empty;
  logic [5:0] in_fid;
  logic       in_hs, in_vs;
  logic [7:0] in_h, in_v;

  // Reference model state
  int          t;
  logic [7:0]  fifo_byte;
  logic [7:0]  m_pix;
  logic        m_hs, m_vs, m_blank, m_uf;
  logic [15:0] m_cnt;
  logic [12:0] m_line;
  logic [23:0] m_cfg;

  int req_t[$];
  int req_l[$];
  int n_req, n_rd, n_vs;

  function automatic int pos_h(input int c);
    return c % HT;
  endfunction

  function automatic int pos_v(input int c);
    return (VT - 1 + c / HT) % VT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic [23:0] obs_cfg();
    return {oFRAME_ID, oOFFSET_H_SIGN, oOFFSET_H, oOFFSET_V_SIGN, oOFFSET_V};
  endfunction

  // Entered at a falling edge; drives the cycle, checks it, advances the model, waits for the next falling edge.
  task automatic cycle();
    int h, v;
    logic act, rq;
    h = pos_h(t);
    v = pos_v(t);
    act = (h < HA) && (v < VA);
    iFIFO_EMPTY = in_empty;
    iFIFO_RDATA = in_empty ? 8'($urandom) : fifo_byte;
    iFRAME_ID = in_fid;
    iOFFSET_H_SIGN = in_hs;
    iOFFSET_H = in_h;
    iOFFSET_V_SIGN = in_vs;
    iOFFSET_V = in_v;
    #1;
    rq = (h == HA - 1) && (((v + 1) % VT) < VA);
    if (rq) m_line = 13'((v + 1) % VT);
    chk("req", 32'(oVGA_LOAD_TO_FIFO_REQ), 32'(rq));
    chk("line", 32'(oVGA_LINE_TO_LOAD), 32'(m_line));
    chk("rdreq", 32'(oFIFO_RDREQ), 32'(act && !in_empty));
    chk("pix", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'({m_pix, m_pix, m_pix}));
    chk("hs", 32'(oVGA_HS), 32'(m_hs));
    chk("vs", 32'(oVGA_VS), 32'(m_vs));
    chk("blank_n", 32'(oVGA_BLANK_N), 32'(m_blank));
    chk("uf", 32'(oUNDERFLOW), 32'(m_uf));
    chk("uf_cnt", 32'(oUNDERFLOW_CNT), 32'(m_cnt));
    chk("cfg", 32'(obs_cfg()), 32'(m_cfg));
    if (oVGA_LOAD_TO_FIFO_REQ === 1'b1) begin
      req_t.push_back(t);
      req_l.push_back(int'(oVGA_LINE_TO_LOAD));
      n_req++;
    end
    if (oFIFO_RDREQ === 1'b1) n_rd++;
    if (oVGA_VS === 1'b1) n_vs++;
    m_pix = (act && !in_empty) ? iFIFO_RDATA : 8'd0;
    m_hs = (h >= HSS) && (h < HSE);
    m_vs = (v >= VSS) && (v < VSE);
    m_blank = act;
    if (act && in_empty) begin
      m_uf = 1'b1;
`ifdef VGA_UNDERFLOW_CNT_EN
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
    if (h == 0 && v == VT - 1) m_cfg = {in_fid, in_hs, in_h, in_vs, in_v};
    if (act && !in_empty) fifo_byte = fifo_byte + 8'd1;
    t++;
    @(negedge iCLK);
  endtask

  task automatic apply_reset();
    iRST = 1'b1;
    #1;
    chk("rst_req", 32'(oVGA_LOAD_TO_FIFO_REQ), 32'd0);
    chk("rst_line", 32'(oVGA_LINE_TO_LOAD), 32'd0);
    chk("rst_rdreq", 32'(oFIFO_RDREQ), 32'd0);
    chk("rst_pix", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
    chk("rst_sync", 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N}), 32'd0);
    chk("rst_uf", 32'(oUNDERFLOW), 32'd0);
    chk("rst_uf_cnt", 32'(oUNDERFLOW_CNT), 32'd0);
    chk("rst_cfg", 32'(obs_cfg()), 32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    t = 0;
    m_pix = '0; m_hs = 0; m_vs = 0; m_blank = 0; m_uf = 0;
    m_cnt = '0; m_line = '0; m_cfg = '0;
  endtask

  // Requests in the first two lines after reset release: last blank line loads line 0, then line 1.
  task automatic check_first_reqs(input string tag);
    req_t.delete();
    req_l.delete();
    repeat (2 * HT) cycle();
    chk({tag, "_n"}, 32'(req_t.size()), 32'd2);
    if (req_t.size() == 2) begin
      chk({tag, "_t0"}, 32'(req_t[0]), 32'(HA - 1));
      chk({tag, "_l0"}, 32'(req_l[0]), 32'd0);
      chk({tag, "_dt"}, 32'(req_t[1] - req_t[0]), 32'(HT));
      chk({tag, "_l1"}, 32'(req_l[1]), 32'd1);
    end
  endtask

  // vt < 0 means any active line.
  task automatic run_to(input int ht, input int vt, input string tag);
    int n = 0;
    while (!(pos_h(t) == ht && (vt < 0 ? pos_v(t) < VA : pos_v(t) == vt)) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < 2 * FRAME), 32'd1);
  endtask

  initial begin
    iRST = 1'b0;
    fifo_byte = 8'd0;
    in_empty = 1'b0;
    in_fid = 6'd3;
    in_hs = 1'($urandom);
    in_h = 8'($urandom);
    in_vs = 1'($urandom);
    in_v = 8'($urandom);
    iFIFO_EMPTY = 1'b0;
    iFIFO_RDATA = 8'd0;
    iFRAME_ID = in_fid;
    iOFFSET_H_SIGN = in_hs;
    iOFFSET_H = in_h;
    iOFFSET_V_SIGN = in_vs;
    iOFFSET_V = in_v;
    t = 0;
    @(negedge iCLK);
    apply_reset();

    check_first_reqs("first");

    // One full frame window with a never-empty FIFO
    n_req = 0; n_rd = 0; n_vs = 0;
    req_l.delete();
    repeat (FRAME) cycle();
    chk("frame_reqs", 32'(n_req), 32'(VA));
    chk("frame_rdreq", 32'(n_rd), 32'(HA * VA));
    chk("frame_vs", 32'(n_vs), 32'((VSE - VSS) * HT));
    chk("frame_max_line", 32'(req_l.max()[0]), 32'(VA - 1));

    // Mid-frame frame-id change only lands at the latch point
    in_fid = 6'd5;
    run_to(0, VT - 1, "fid_reach");
    chk("fid_hold", 32'(oFRAME_ID), 32'd3);
    cycle();
    chk("fid_new", 32'(oFRAME_ID), 32'd5);

    // Ten empty cycles at the start of an active line
    run_to(0, 0, "uf_reach");
    chk("uf_pre", 32'(oUNDERFLOW), 32'd0);
    in_empty = 1'b1;
    repeat (10) cycle();
    in_empty = 1'b0;
    chk("uf_set", 32'(oUNDERFLOW), 32'd1);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("uf_cnt10", 32'(oUNDERFLOW_CNT), 32'd10);
`else
    chk("uf_cnt10", 32'(oUNDERFLOW_CNT), 32'd0);
`endif

    // Random FIFO availability and occasional parameter changes
    repeat (1200) begin
      in_empty = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        in_fid = 6'($urandom);
        in_hs = 1'($urandom);
        in_h = 8'($urandom);
        in_vs = 1'($urandom);
        in_v = 8'($urandom);
      end
      cycle();
    end
    chk("uf_sticky", 32'(oUNDERFLOW), 32'd1);

    // Reset in the middle of an active line
    in_empty = 1'b0;
    run_to(HA / 2, -1, "midrst_reach");
    apply_reset();
    check_first_reqs("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_line_requester.md
VGA_LINE_REQUESTER -- requirements
Module: vga_line_requester

Interface
- REQ-001 Parameters (name, default, meaning), one per line:
  - H_ACTIVE, 1280: visible pixels per line.
  - H_TOTAL, 1688: pixels per line including blanking.
  - H_SYNC_START, 1328: first pixel of HSYNC.
  - H_SYNC_END, 1440: first pixel after HSYNC.
  - V_ACTIVE, 1024: visible lines.
  - V_TOTAL, 1066: lines per frame.
  - V_SYNC_START, 1025: first line of VSYNC.
  - V_SYNC_END, 1028: first line after VSYNC.
- REQ-002 Ports (name, direction, width, meaning), one per line:
  - iCLK, in, 1: pixel clock; the only clock.
  - iRST, in, 1: reset, asynchronous, active-high.
  - iFRAME_ID, in, 6: frame selection, sampled once per frame.
  - iOFFSET_H_SIGN / iOFFSET_H, in, 1/8: horizontal offset, sampled once per frame.
  - iOFFSET_V_SIGN / iOFFSET_V, in, 1/8: vertical offset, sampled once per frame.
  - oFRAME_ID, oOFFSET_H_SIGN, oOFFSET_H, oOFFSET_V_SIGN, oOFFSET_V, out, 6/1/8/1/8: frame-stable copies of the above.
  - oVGA_LINE_TO_LOAD, out, 13: line number for the next line load.
  - oVGA_LOAD_TO_FIFO_REQ, out, 1: single-cycle line-load request.
  - iFIFO_EMPTY, in, 1: VGA FIFO empty (show-ahead FIFO).
  - iFIFO_RDATA, in, 8: VGA FIFO head data.
  - oFIFO_RDREQ, out, 1: FIFO read acknowledge.
  - oVGA_R/G/B, out, 8 each: pixel value; the same grey byte on all three.
  - oVGA_HS, oVGA_VS, out, 1: syncs, active-high.
  - oVGA_BLANK_N, out, 1: high while in the active area.
  - oUNDERFLOW, out, 1: sticky underflow flag.
  - oUNDERFLOW_CNT, out, 16: underflow count (see Configuration).

Function
- REQ-003 h_cnt counts 0..H_TOTAL-1 and wraps to 0; v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1 to 0.
- REQ-004 Active area is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; sync high while the counter lies in [SYNC_START, SYNC_END).
- REQ-005 Parameter latch: at v_cnt==V_TOTAL-1 and h_cnt==0, all iFRAME_ID/iOFFSET_* inputs are registered into the o* copies; the copies are otherwise held.
- REQ-006 Request FSM states and transitions:
  - ST_IDLE -> ST_REQ when h_cnt==H_ACTIVE-1 and next_line<V_ACTIVE.
  - ST_REQ lasts exactly 1 cycle with oVGA_LOAD_TO_FIFO_REQ=1, then goes to ST_HOLD.
  - ST_HOLD -> ST_IDLE when h_cnt==H_TOTAL-1.
- REQ-007 next_line = v_cnt+1, or 0 when v_cnt==V_TOTAL-1; it is zero-extended to 13 bits on oVGA_LINE_TO_LOAD and held from ST_REQ until the next request.
- REQ-008 No request is issued for next_line in V_ACTIVE..V_TOTAL-1; exactly V_ACTIVE requests are issued per frame.
- REQ-009 oFIFO_RDREQ = active && !iFIFO_EMPTY (combinational).
- REQ-010 Pixel output pipeline, one register stage:
  - oVGA_R/G/B = iFIFO_RDATA when active and not empty; 0 when active and empty; 0 when blank.
  - oVGA_HS, oVGA_VS and oVGA_BLANK_N are delayed by the same one stage, so pixel and syncs stay aligned.
- REQ-011 Underflow: active && iFIFO_EMPTY sets oUNDERFLOW, one event per cycle; only reset clears it.
- REQ-012 The FIFO is never read outside the active area; any bytes left in the FIFO at line end stay and are consumed by the next line. This is accepted misalignment, flagged only by upstream behaviour.

Reset
- REQ-013 iRST asserted (async) sets:
  - h_cnt=0, v_cnt=V_TOTAL-1, FSM=ST_IDLE.
  - All outputs 0; oVGA_BLANK_N=0.
  - Latched parameter copies = 0.
- REQ-014 The first line after reset deassertion is the last blank line, so the line-0 request precedes the first active line; reset mid-line aborts the line with no further request until the counters re-reach the trigger point.

Configuration
- REQ-015 Macro VGA_UNDERFLOW_CNT_EN:
  - Defined: oUNDERFLOW_CNT is a 16-bit saturating counter (stops at 16'hFFFF), incremented on each underflow cycle, cleared by reset.
  - Undefined: oUNDERFLOW_CNT is tied to 0 and no counter logic exists.

Verification
- REQ-016 Release reset with FIFO never empty:
  - First oVGA_LOAD_TO_FIFO_REQ pulse occurs at cycle 1279 with oVGA_LINE_TO_LOAD=0.
  - The next pulse occurs 1688 cycles later with line=1.
- REQ-017 Run one full frame: exactly 1024 request pulses, none for lines 1024..1065; oVGA_VS high for lines 1025..1027.
- REQ-018 FIFO supplies the bytes 0..255 repeating: oVGA_R at pixel n equals n mod 256, appearing one cycle after h_cnt==n; 1280 oFIFO_RDREQ per line.
- REQ-019 Force iFIFO_EMPTY=1 for 10 active cycles:
  - Pixels read 0 and oUNDERFLOW=1.
  - With the macro defined, oUNDERFLOW_CNT=10; without it, 0.
- REQ-020 Change iFRAME_ID from 3 to 5 at mid-frame: oFRAME_ID stays 3 until v_cnt==1065,h_cnt==0, then becomes 5.
- REQ-021 Assert iRST at mid-line (h_cnt=600):
  - All outputs 0 immediately.
  - The post-release sequence matches REQ-016.
